icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Responder end of the instruction-fetch request/response interface.
- Accepts a PC request from the fetch stage and returns the 32-bit instruction.
- Built as a direct-mapped, blocking instruction cache.
- On a miss it refills one line from a 64-bit backing-memory read port before responding.

Parameters:
- NUM_SETS, 64, number of cache lines; power of two.
- BEATS, 2, 64-bit beats per line; power of two; line bytes = 8*BEATS.
- AW, 64, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  AW  instruction byte address; bits [1:0] ignored.
- resp_valid  out  1  instruction valid.
- resp_ready  in  1  fetch stage accepts the instruction.
- resp_instr  out  32  instruction word.
- flush  in  1  one-cycle pulse: invalidate all lines.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  AW  line-aligned address.
- mem_resp_valid  in  1  beat valid; memory returns beats in order, beat 0 first.
- mem_resp_data  in  64  beat data.

Behaviour:
- Reset: rst=0 asynchronously forces state IDLE, all valid bits 0, beat counter 0 and held address 0.
  - All outputs are 0 while rst=0, including req_ready.
  - Tag/data arrays are not reset.
- Address split: offset = [log2(8*BEATS)-1:0]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
  - Beat select = addr[log2(8*BEATS)-1:3]; addr[2] selects the upper (1) or lower (0) 32-bit half of the beat.
- State machine:
  - IDLE: req_ready=1. When req_valid&&req_ready, latch req_addr and go to LOOKUP.
  - LOOKUP: hit = valid[index] && tag match.
    - Hit: register the selected word into resp_instr and go to RESP.
    - Miss: go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1, mem_req_addr = held address with the offset zeroed.
    - Address is stable while waiting; on mem_req_ready go to REFILL.
  - REFILL: each mem_resp_valid writes mem_resp_data into data[index][beat_cnt], then beat_cnt increments.
    - On beat BEATS-1: write the tag, set valid[index], load resp_instr from the buffered line (the requested word may be in the final beat), clear beat_cnt, go to RESP.
  - RESP: resp_valid=1; resp_instr is stable until resp_ready. On resp_valid&&resp_ready go to IDLE.
- Latency:
  - Hit: resp_valid is asserted 2 cycles after the request handshake.
  - Miss: resp_valid is asserted 1 cycle after the last refill beat.
  - Throughput: one request in flight; req_ready=0 outside IDLE. The next request can be accepted 1 cycle after the response handshake.
- Boundaries:
  - mem_resp_valid outside REFILL is ignored.
  - beat_cnt wraps to 0 after BEATS-1.
  - flush in any state clears all valid bits on the next edge. The pending response is still delivered with correct data.
  - flush in the same cycle as the final refill beat: flush wins and the line is left invalid.
  - flush on the same cycle as a hit in LOOKUP: hit data is still returned.
  - Conflict misses simply overwrite the line.
  - resp_ready held low stalls in RESP indefinitely without corrupting resp_instr.

Decomposition:
- Shared package icache_pkg holds:
  - state enum IDLE/LOOKUP/MISS_REQ/REFILL/RESP;
  - the address-field width functions (offset, index and tag widths derived from NUM_SETS/BEATS/AW).
- One sub-module, icache_array: flop-based tag/valid/data storage.
  - Ports: read index, write index, beat-write enable, tag write, valid set, flush-all.
  - Owns the valid-bit reset and flush logic.
- FSM and word select stay in icache_responder.

Test Plan:
- Reset, then request 0x1000 with memory returning beat0=0x1111_2222_3333_4444 and beat1=0x5555_6666_7777_8888 → mem_req_addr=0x1000, resp_instr=0x33334444, valid[index 0] set.
- Second request to 0x100C on the same line → no mem_req_valid; resp_instr=0x55556666 exactly 2 cycles after the handshake.
- Request 0x1400 (same index, new tag) → miss refill; a following request to 0x1000 misses again (eviction).
- resp_ready held 0 for 5 cycles in RESP → resp_valid and resp_instr stable, req_ready=0; completes on resp_ready=1.
- Pulse flush during the last refill beat → response delivered; a repeat request to the same address misses.
- Assert rst=0 mid-REFILL → immediate IDLE with all outputs 0; after release the same address misses and refills cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the instruction cache responder.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP
  } state_t;

  function automatic int offset_w(input int beats);
    return $clog2(8 * beats);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int aw, input int num_sets, input int beats);
    return aw - offset_w(beats) - index_w(num_sets);
  endfunction

  // Keeps the beat counter at least one bit wide when a line is a single beat.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Flop-based tag/valid/data storage for a direct-mapped cache; valid bits reset and flush here.
module icache_array #(
  parameter int NUM_SETS = 64,
  parameter int BEATS    = 2,
  parameter int TAG_W    = 54,
  parameter int IDX_W    = 6,
  parameter int BEAT_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [64*BEATS-1:0]   rd_line,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic                  beat_we,
  input  logic [63:0]           wr_data,
  input  logic                  tag_we,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  valid_set,
  input  logic                  flush_all
);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [63:0]         data [NUM_SETS][BEATS];

  // Flush takes priority so a line completing on the same edge stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (valid_set) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) begin
      data[wr_idx][wr_beat] <= wr_data;
    end
    if (tag_we) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];

  always_comb begin
    rd_line = '0;
    for (int b = 0; b < BEATS; b++) begin
      rd_line[b*64 +: 64] = data[rd_idx][b];
    end
  end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped blocking instruction cache answering fetch requests; refills a line
// from a 64-bit memory port on a miss before responding.
module icache_responder
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int BEATS    = 2,
  parameter int AW       = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_instr,
  input  logic          flush,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_resp_valid,
  input  logic [63:0]   mem_resp_data
);

  localparam int OFF_W  = offset_w(BEATS);
  localparam int IDX_W  = index_w(NUM_SETS);
  localparam int TAG_W  = tag_w(AW, NUM_SETS, BEATS);
  localparam int BEAT_W = beat_w(BEATS);
  localparam int WORDS  = 2 * BEATS;
  localparam int WSEL_W = OFF_W - 2;

  state_t state, state_nx;

  logic [AW-1:0]       addr_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [31:0]         instr_q;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WSEL_W-1:0]   wsel;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [64*BEATS-1:0] rd_line;
  logic [64*BEATS-1:0] refill_line;
  logic [WORDS-1:0][31:0] hit_words;
  logic [WORDS-1:0][31:0] fill_words;
  logic                hit;
  logic                last_beat;
  logic                beat_fire;
  logic                unused_bits;

  assign idx         = addr_q[OFF_W +: IDX_W];
  assign tag         = addr_q[AW-1 -: TAG_W];
  assign wsel        = addr_q[OFF_W-1:2];
  assign unused_bits = ^addr_q[1:0];

  assign hit       = rd_valid && (rd_tag == tag);
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign beat_fire = (state == REFILL) && mem_resp_valid;

  // The final beat is not in the array yet, so splice it in from the bus.
  always_comb begin
    refill_line = rd_line;
    refill_line[(BEATS-1)*64 +: 64] = mem_resp_data;
  end

  assign hit_words  = rd_line;
  assign fill_words = refill_line;

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .BEATS    (BEATS),
    .TAG_W    (TAG_W),
    .IDX_W    (IDX_W),
    .BEAT_W   (BEAT_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (idx),
    .wr_beat   (beat_cnt),
    .beat_we   (beat_fire),
    .wr_data   (mem_resp_data),
    .tag_we    (beat_fire && last_beat),
    .wr_tag    (tag),
    .valid_set (beat_fire && last_beat),
    .flush_all (flush)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid) state_nx = LOOKUP;
      end
      LOOKUP:   state_nx = hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nx = REFILL;
      end
      REFILL:   if (mem_resp_valid && last_beat) state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      beat_cnt <= '0;
      instr_q  <= '0;
    end else begin
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == LOOKUP && hit) instr_q <= hit_words[wsel];
      if (beat_fire) begin
        if (last_beat) begin
          beat_cnt <= '0;
          instr_q  <= fill_words[wsel];
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign resp_instr   = instr_q;
  assign mem_req_addr = {addr_q[AW-1:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_responder.sv
// Scenario bench for icache_responder: a behavioural memory answers refills and a
// queue of expected instructions is checked against each response.
module tb_icache_responder;

  localparam int NUM_SETS = 64;
  localparam int BEATS    = 2;
  localparam int AW       = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_instr;
  logic          flush = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 1'b0;
  logic [63:0]   mem_resp_data = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache_responder #(
    .NUM_SETS (NUM_SETS),
    .BEATS    (BEATS),
    .AW       (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_instr     (resp_instr),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  // Memory contents: the line at 0x1000 holds fixed beats, everything else is address-derived.
  function automatic logic [31:0] exp_word(input logic [63:0] a);
    logic [63:0] la;
    la = a & ~64'hF;
    if (la == 64'h1000) begin
      case (a[3:2])
        2'd0:    return 32'h3333_4444;
        2'd1:    return 32'h1111_2222;
        2'd2:    return 32'h7777_8888;
        default: return 32'h5555_6666;
      endcase
    end
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] la, input int b);
    return {exp_word(la + 64'(8 * b) + 64'd4), exp_word(la + 64'(8 * b))};
  endfunction

  task automatic run_req(input string name, input logic [63:0] a, input bit exp_miss,
                         input bit flush_last, input bit flush_lookup, input int stall,
                         input bit junk);
    int          cyc;
    bit          saw_mem;
    logic [63:0] la;
    logic [31:0] exp_w;
    la = a & ~64'hF;
    @(negedge clk);
    req_addr  = a;
    req_valid = 1'b1;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready got=%b want=1", name, req_ready);
    end
    exp_q.push_back(exp_word(a));
    @(negedge clk);
    req_valid      = 1'b0;
    flush          = flush_lookup;
    mem_resp_valid = junk;
    mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc     = 1;
    saw_mem = 1'b0;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      if (mem_req_valid === 1'b1 && !saw_mem) begin
        saw_mem = 1'b1;
        checks++;
        if (mem_req_addr !== la) begin
          errors++;
          $display("FAIL %s mem_req_addr got=%h want=%h", name, mem_req_addr, la);
        end
        @(negedge clk);
        cyc++;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== la) begin
          errors++;
          $display("FAIL %s mem_req_hold valid=%b addr=%h want valid=1 addr=%h",
                   name, mem_req_valid, mem_req_addr, la);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        cyc++;
        mem_req_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s refill_outputs req_ready=%b mem_req_valid=%b want 0 0",
                   name, req_ready, mem_req_valid);
        end
        for (int b = 0; b < BEATS; b++) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = beat_data(la, b);
          flush          = flush_last && (b == BEATS - 1);
          @(negedge clk);
          cyc++;
        end
        mem_resp_valid = junk;
        mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        flush          = 1'b0;
        checks++;
        if (resp_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s miss_latency resp_valid got=%b want=1", name, resp_valid);
        end
      end else begin
        @(negedge clk);
        cyc++;
        flush = 1'b0;
      end
    end
    flush = 1'b0;
    exp_w = exp_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_timeout resp_valid got=%b want=1", name, resp_valid);
      mem_resp_valid = 1'b0;
      return;
    end
    checks++;
    if (saw_mem !== exp_miss) begin
      errors++;
      $display("FAIL %s miss_flag got=%b want=%b", name, saw_mem, exp_miss);
    end
    if (!exp_miss) begin
      checks++;
      if (cyc != 2) begin
        errors++;
        $display("FAIL %s hit_latency got=%0d want=2", name, cyc);
      end
    end
    checks++;
    if (resp_instr !== exp_w) begin
      errors++;
      $display("FAIL %s resp_instr got=%h want=%h", name, resp_instr, exp_w);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_instr !== exp_w || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d valid=%b instr=%h req_ready=%b want 1 %h 0",
                 name, s, resp_valid, resp_instr, req_ready, exp_w);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready     = 1'b0;
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_handshake resp_valid=%b req_ready=%b want 0 1",
               name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, resp_valid, mem_req_valid} !== 3'b000 || resp_instr !== 32'h0 ||
        mem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs rr=%b rv=%b mv=%b instr=%h maddr=%h want all 0",
               req_ready, resp_valid, mem_req_valid, resp_instr, mem_req_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_miss_refill();
    run_req("miss_1000", 64'h1000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_hit();
    run_req("hit_100d", 64'h100D, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_req("hit_1008", 64'h1008, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_conflict();
    run_req("conflict_1400", 64'h1400, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_req("evicted_1000", 64'h1000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_req("stall_1004", 64'h1004, 1'b0, 1'b0, 1'b0, 5, 1'b0);
  endtask

  task automatic test_flush();
    run_req("flush_last_2008", 64'h2008, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_req("after_flush_2008", 64'h2008, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_req("flush_lookup_200c", 64'h200C, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_req("after_flush_200c", 64'h200C, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      run_req("b2b_fill", 64'h4000 + 64'(i * 16), 1'b1, 1'b0, 1'b0, 0, 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      run_req("b2b_hit", 64'h4000 + 64'(i * 16) + 64'(4 * (i - 1)), 1'b0, 1'b0, 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    @(negedge clk);
    req_addr  = 64'h5000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (mem_req_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_refill mem_req_valid got=%b want=1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = beat_data(64'h5000, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_refill flags rr=%b rv=%b mv=%b want 000",
               req_ready, resp_valid, mem_req_valid);
    end
    checks++;
    if (resp_instr !== 32'h0 || mem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL rst_refill data instr=%h maddr=%h want 0 0", resp_instr, mem_req_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    run_req("after_rst_5000", 64'h5000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_req("after_rst_4010", 64'h4010, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_req("after_rst_5004", 64'h5004, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_conflict();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
